// File: rtl/fpu_pkg.sv
// Shared types and funct3 decode for the sign-injection scheduler.
package fpu_pkg;

    typedef enum logic [1:0] {
        SGNJ     = 2'd0,
        SGNJN    = 2'd1,
        SGNJX    = 2'd2,
        SGNJ_ILL = 2'd3
    } sgnj_op_e;

    localparam logic [2:0] FUNCT3_FSGNJ  = 3'b000;
    localparam logic [2:0] FUNCT3_FSGNJN = 3'b001;
    localparam logic [2:0] FUNCT3_FSGNJX = 3'b010;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        sgnj_op_e    op;
    } sgnj_req_t;

    function automatic sgnj_op_e decode_funct3(input logic [2:0] funct3);
        case (funct3)
            FUNCT3_FSGNJ:  return SGNJ;
            FUNCT3_FSGNJN: return SGNJN;
            FUNCT3_FSGNJX: return SGNJX;
            default:       return SGNJ_ILL;
        endcase
    endfunction

endpackage

// File: rtl/fpu_fsgnj.sv
// Combinational single-precision sign injection; illegal op yields zero.
module fpu_fsgnj
    import fpu_pkg::*;
(
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  sgnj_op_e    op_i,
    output logic [31:0] rd_c_o
);
    always_comb begin
        rd_c_o = '0;
        case (op_i)
            SGNJ:    rd_c_o = {rs2_i[31], rs1_i[30:0]};
            SGNJN:   rd_c_o = {~rs2_i[31], rs1_i[30:0]};
            SGNJX:   rd_c_o = {rs1_i[31] ^ rs2_i[31], rs1_i[30:0]};
            default: rd_c_o = '0;
        endcase
    end
endmodule

// File: rtl/fpu_rr_arb.sv
// Round-robin arbiter: first valid requester at or after ptr, wrapping; ptr advances past each grant.
module fpu_rr_arb #(
    parameter int unsigned N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_i,
    input  logic                 en_i,
    output logic [N-1:0]         grant_c_o,
    output logic [$clog2(N)-1:0] idx_c_o,
    output logic                 valid_c_o
);
    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] ptr_q, ptr_d;
    int unsigned   cand;
    logic          found;

    always_comb begin
        found   = 1'b0;
        idx_c_o = '0;
        cand    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) cand = cand - N;
            if (!found && req_i[IW'(cand)]) begin
                found   = 1'b1;
                idx_c_o = IW'(cand);
            end
        end
        valid_c_o = found && en_i;
        grant_c_o = valid_c_o ? (N'(1) << idx_c_o) : '0;
        ptr_d     = ptr_q;
        if (valid_c_o) begin
            ptr_d = (int'(idx_c_o) == N - 1) ? '0 : idx_c_o + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fpu_sgnj_sched.sv
// Shares one fsgnj datapath among NUM_REQ requesters with a registered valid/ready result.
// Optional FPU_SGNJ_STATS_EN adds saturating issued/illegal counters.
module fpu_sgnj_sched
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*32-1:0]      req_rs1,
    input  logic [NUM_REQ*32-1:0]      req_rs2,
    input  logic [NUM_REQ*3-1:0]       req_funct3,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [31:0]                resp_rd,
    output logic [TAG_W-1:0]           resp_tag,
    output logic [$clog2(NUM_REQ)-1:0] resp_src,
    output logic                       resp_illegal,
`ifdef FPU_SGNJ_STATS_EN
    output logic [31:0]                stat_issued,
    output logic [31:0]                stat_illegal,
`endif
    output logic                       busy
);
    localparam int unsigned IW = $clog2(NUM_REQ);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [31:0]       rd_q, rd_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [IW-1:0]     src_q, src_d;
    logic              ill_q, ill_d;

    logic              accept_c;
    logic [NUM_REQ-1:0] gnt_c;
    logic [IW-1:0]     gnt_idx_c;
    logic              gnt_any_c;
    sgnj_req_t         sel_c;
    logic [TAG_W-1:0]  sel_tag_c;
    logic [31:0]       rd_c;

    assign accept_c = (state_q == ST_EMPTY) || resp_ready;

    fpu_rr_arb #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .en_i      (accept_c && !rst),
        .grant_c_o (gnt_c),
        .idx_c_o   (gnt_idx_c),
        .valid_c_o (gnt_any_c)
    );

    // Payload of the granted requester feeds the shared datapath.
    always_comb begin
        sel_c.rs1 = req_rs1[int'(gnt_idx_c)*32 +: 32];
        sel_c.rs2 = req_rs2[int'(gnt_idx_c)*32 +: 32];
        sel_c.op  = decode_funct3(req_funct3[int'(gnt_idx_c)*3 +: 3]);
        sel_tag_c = req_tag[int'(gnt_idx_c)*TAG_W +: TAG_W];
    end

    fpu_fsgnj u_fsgnj (
        .rs1_i  (sel_c.rs1),
        .rs2_i  (sel_c.rs2),
        .op_i   (sel_c.op),
        .rd_c_o (rd_c)
    );

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        tag_d   = tag_q;
        src_d   = src_q;
        ill_d   = ill_q;
        case (state_q)
            ST_EMPTY: if (gnt_any_c) state_d = ST_FULL;
            ST_FULL:  if (resp_ready && !gnt_any_c) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (gnt_any_c) begin
            rd_d  = rd_c;
            tag_d = sel_tag_c;
            src_d = gnt_idx_c;
            ill_d = (sel_c.op == SGNJ_ILL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            rd_q    <= '0;
            tag_q   <= '0;
            src_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            tag_q   <= tag_d;
            src_q   <= src_d;
            ill_q   <= ill_d;
        end
    end

`ifdef FPU_SGNJ_STATS_EN
    logic [31:0] issued_q, illegal_q;

    // Saturating grant counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q  <= '0;
            illegal_q <= '0;
        end else if (gnt_any_c) begin
            if (issued_q != 32'hFFFF_FFFF) issued_q <= issued_q + 32'd1;
            if (sel_c.op == SGNJ_ILL && illegal_q != 32'hFFFF_FFFF)
                illegal_q <= illegal_q + 32'd1;
        end
    end

    assign stat_issued  = issued_q;
    assign stat_illegal = illegal_q;
`endif

    assign req_ready    = gnt_c;
    assign resp_valid   = (state_q == ST_FULL);
    assign resp_rd      = rd_q;
    assign resp_tag     = tag_q;
    assign resp_src     = src_q;
    assign resp_illegal = ill_q;
    assign busy         = resp_valid || (|req_valid);

endmodule

// File: tb/tb_fpu_sgnj_sched.sv
// Directed, table-driven bench for fpu_sgnj_sched (NUM_REQ=2, TAG_W=4).
module tb_fpu_sgnj_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_rs1, req_rs2;
    logic [5:0]  req_funct3;
    logic [7:0]  req_tag;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rd;
    logic [3:0]  resp_tag;
    logic [0:0]  resp_src;
    logic        resp_illegal, busy;
`ifdef FPU_SGNJ_STATS_EN
    logic [31:0] stat_issued, stat_illegal;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ptr  = 0;
    int exp_issued = 0;
    int exp_ill_cnt = 0;

    always #5 clk = ~clk;

    fpu_sgnj_sched #(.NUM_REQ(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rd(resp_rd), .resp_tag(resp_tag), .resp_src(resp_src),
        .resp_illegal(resp_illegal),
`ifdef FPU_SGNJ_STATS_EN
        .stat_issued(stat_issued), .stat_illegal(stat_illegal),
`endif
        .busy(busy)
    );

    typedef struct {
        int          src;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  f3;
        logic [3:0]  tag;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int src, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [2:0] f3, input logic [3:0] tag);
        req_rs1[src*32 +: 32]  = rs1;
        req_rs2[src*32 +: 32]  = rs2;
        req_funct3[src*3 +: 3] = f3;
        req_tag[src*4 +: 4]    = tag;
    endtask

    initial begin
        vecs[0] = '{0, 32'h3F80_0000, 32'hC000_0000, 3'b000, 4'h5, 32'hBF80_0000, 1'b0};
        vecs[1] = '{1, 32'hBF80_0000, 32'hC000_0000, 3'b001, 4'h1, 32'h3F80_0000, 1'b0};
        vecs[2] = '{0, 32'hBF80_0000, 32'hC000_0000, 3'b010, 4'h2, 32'h3F80_0000, 1'b0};
        vecs[3] = '{1, 32'h3F80_0000, 32'hC000_0000, 3'b011, 4'h3, 32'h0000_0000, 1'b1};
        vecs[4] = '{0, 32'h4049_0FDB, 32'h0000_0000, 3'b000, 4'h7, 32'h4049_0FDB, 1'b0};
        vecs[5] = '{1, 32'h4049_0FDB, 32'h0000_0000, 3'b001, 4'h9, 32'hC049_0FDB, 1'b0};
        vecs[6] = '{0, 32'hC049_0FDB, 32'h8000_0000, 3'b010, 4'hA, 32'h4049_0FDB, 1'b0};
        vecs[7] = '{1, 32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 4'hF, 32'h0000_0000, 1'b1};
        vecs[8] = '{0, 32'h0000_0000, 32'h8000_0000, 3'b001, 4'h0, 32'h0000_0000, 1'b0};

        rst = 1'b1; req_valid = 2'b11; resp_ready = 1'b0;
        req_rs1 = '0; req_rs2 = '0; req_funct3 = '0; req_tag = '0;
        drive(0, 32'h3F80_0000, 32'h8000_0000, 3'b000, 4'hC);
        drive(1, 32'h4000_0000, 32'h0000_0000, 3'b000, 4'hD);
        repeat (2) @(posedge clk);
        #1;
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_rd", resp_rd, 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk); rst = 1'b0; resp_ready = 1'b1;
        #1;
        check("first_grant_req0", 32'(req_ready), 32'd1);
        exp_ptr = 1; exp_issued++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("first_resp_src", 32'(resp_src), 32'd0);
        check("first_resp_rd", resp_rd, 32'hBF80_0000);
        @(posedge clk); #1;
        check("drain_empty", 32'(resp_valid), 32'd0);

        // Single-requester vectors
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].src, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].tag);
            req_valid = 2'(1 << vecs[i].src);
            #1;
            check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(1 << vecs[i].src));
            exp_ptr = (vecs[i].src + 1) % 2;
            exp_issued++;
            if (vecs[i].exp_ill) exp_ill_cnt++;
            @(posedge clk); #1;
            req_valid = 2'b00;
            check($sformatf("v%0d_valid", i), 32'(resp_valid), 32'd1);
            check($sformatf("v%0d_rd", i), resp_rd, vecs[i].exp_rd);
            check($sformatf("v%0d_tag", i), 32'(resp_tag), 32'(vecs[i].tag));
            check($sformatf("v%0d_src", i), 32'(resp_src), 32'(vecs[i].src));
            check($sformatf("v%0d_ill", i), 32'(resp_illegal), 32'(vecs[i].exp_ill));
        end
`ifdef FPU_SGNJ_STATS_EN
        check("stat_issued", stat_issued, 32'(exp_issued));
        check("stat_illegal", stat_illegal, 32'(exp_ill_cnt));
`endif

        // Fairness: both valid, one result per cycle, alternating grants
        drive(0, 32'h3F80_0000, 32'h0000_0000, 3'b001, 4'h4);
        drive(1, 32'h4000_0000, 32'h0000_0000, 3'b000, 4'h8);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            int g;
            #1;
            g = exp_ptr;
            check($sformatf("fair%0d_ready", k), 32'(req_ready), 32'(1 << g));
            exp_ptr = 1 - g;
            @(posedge clk); #1;
            check($sformatf("fair%0d_src", k), 32'(resp_src), 32'(g));
            check($sformatf("fair%0d_rd", k), resp_rd, (g == 0) ? 32'hBF80_0000 : 32'h4000_0000);
        end

        // Backpressure: hold FULL three cycles, then retire and load together
        req_valid = 2'b01;
        drive(0, 32'h3F80_0000, 32'h8000_0000, 3'b000, 4'h2);
        #1;
        check("bp_load_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        exp_ptr = 1;
        resp_ready = 1'b0;
        req_valid = 2'b10;
        drive(1, 32'h3F80_0000, 32'h8000_0000, 3'b001, 4'h6);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
            check($sformatf("bp%0d_valid", k), 32'(resp_valid), 32'd1);
            check($sformatf("bp%0d_rd", k), resp_rd, 32'hBF80_0000);
            check($sformatf("bp%0d_tag", k), 32'(resp_tag), 32'h2);
            check($sformatf("bp%0d_busy", k), 32'(busy), 32'd1);
            @(posedge clk);
        end
        #1;
        resp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("bp_new_src", 32'(resp_src), 32'd1);
        check("bp_new_rd", resp_rd, 32'h3F80_0000);
        check("bp_new_tag", 32'(resp_tag), 32'h6);
        @(posedge clk); #1;
        check("bp_retired", 32'(resp_valid), 32'd0);
        check("bp_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset while FULL; pointer returns to 0
        req_valid = 2'b01; resp_ready = 1'b0;
        drive(0, 32'h3F80_0000, 32'h0000_0000, 3'b000, 4'h1);
        @(posedge clk); #1;
        req_valid = 2'b10;
        check("rst_pre_full", 32'(resp_valid), 32'd1);
        #2; rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(resp_valid), 32'd0);
        check("rst_async_rd", resp_rd, 32'd0);
        check("rst_async_ready", 32'(req_ready), 32'd0);
`ifdef FPU_SGNJ_STATS_EN
        check("rst_stat_issued", stat_issued, 32'd0);
`endif
        @(negedge clk); rst = 1'b0; req_valid = 2'b11;
        #1;
        check("rst_ptr_zero", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("rst_after_src", 32'(resp_src), 32'd0);
        check("rst_after_valid", 32'(resp_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
